// File: rtl/mem_pkg.sv
// Shared definitions for the memory access sequencer.
//   state_t       : sequencer states
//   grant_t       : which requester was granted last
//   MODE_*        : decoded access width (also used by the memory-op decoder)
//   illegal_data  : classifies a data request that must not reach memory
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RESP,
    WRITE,
    RMW_RD,
    RMW_WR,
    ERR
  } state_t;

  typedef enum logic {
    FETCH,
    DATA
  } grant_t;

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_BYTE = 3'd1;
  localparam logic [2:0] MODE_WORD = 3'd2;

  // Both load and store, an unknown width, or a word access off a word boundary.
  function automatic logic illegal_data(input logic       ld,
                                        input logic       st,
                                        input logic [2:0] mode,
                                        input logic [1:0] offset);
    logic bad_mode;
    bad_mode = (mode != MODE_BYTE) && (mode != MODE_WORD);
    return (ld && st) || bad_mode || ((mode == MODE_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane helper for a little-endian 32-bit word.
//   word     : source word
//   offset   : byte lane (lane k occupies bits [8k+7:8k])
//   byte_in  : byte to merge into the selected lane
//   byte_ext : selected lane sign-extended to 32 bits
//   merged   : word with the selected lane replaced by byte_in
module mem_byte_lane (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [7:0]  byte_in,
  output logic [31:0] byte_ext,
  output logic [31:0] merged
);

  logic [7:0] lane;

  always_comb begin
    lane     = word[{offset, 3'b000} +: 8];
    byte_ext = {{24{lane[7]}}, lane};
    merged   = word;
    merged[{offset, 3'b000} +: 8] = byte_in;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares one single-port synchronous 32-bit memory between instruction fetch
// and the data stage. Loads/fetches are read-then-respond, word stores are a
// single write, byte stores are read-modify-write, illegal data requests are
// answered with an error flag and never reach memory.
//   clk, rst_n                  : clock, async active-low reset
//   if_req/if_addr              : fetch request (held until if_ready)
//   if_ready/if_rdata           : fetch completion pulse and word
//   d_load/d_store/d_mode       : data request kind and width
//   d_addr/d_wdata              : data byte address and store data
//   d_ready/d_rdata/d_misaligned: data completion pulse, load result, error
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port
//   busy                        : a transaction is in progress
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_load,
  input  logic              d_store,
  input  logic [2:0]        d_mode,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_misaligned,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  state_t            state;
  grant_t            last_grant;
  logic              req_fetch;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              take_data;
  logic              d_illegal;
  logic [31:0]       lane_ext;
  logic [31:0]       lane_merged;

  mem_byte_lane u_lane (
    .word     (mem_rdata),
    .offset   (req_addr[1:0]),
    .byte_in  (req_wdata[7:0]),
    .byte_ext (lane_ext),
    .merged   (lane_merged)
  );

  // Data wins unless fetch is also pending and data was granted last.
  always_comb begin
    take_data = (d_load || d_store) && (!if_req || (last_grant == FETCH));
    d_illegal = illegal_data(d_load, d_store, d_mode, d_addr[1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= FETCH;
      req_fetch  <= 1'b0;
      req_byte   <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_data) begin
            last_grant <= DATA;
            req_fetch  <= 1'b0;
            req_byte   <= (d_mode == MODE_BYTE);
            req_addr   <= d_addr;
            req_wdata  <= d_wdata;
            if (d_illegal)               state <= ERR;
            else if (d_load)             state <= READ;
            else if (d_mode == MODE_WORD) state <= WRITE;
            else                         state <= RMW_RD;
          end else if (if_req) begin
            last_grant <= FETCH;
            req_fetch  <= 1'b1;
            req_byte   <= 1'b0;
            req_addr   <= if_addr;
            state      <= READ;
          end
        end
        READ:    state <= RESP;
        RMW_RD:  state <= RMW_WR;
        RESP,
        WRITE,
        RMW_WR,
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode: every output is zero in IDLE, so reset clears them at once.
  always_comb begin
    busy         = (state != IDLE);
    mem_en       = (state == READ) || (state == WRITE) ||
                   (state == RMW_RD) || (state == RMW_WR);
    mem_we       = (state == WRITE) || (state == RMW_WR);
    mem_addr     = mem_en ? req_addr[ADDR_W-1:2] : '0;
    mem_wdata    = '0;
    if_ready     = 1'b0;
    if_rdata     = '0;
    d_ready      = 1'b0;
    d_rdata      = '0;
    d_misaligned = 1'b0;
    case (state)
      RESP: begin
        if (req_fetch) begin
          if_ready = 1'b1;
          if_rdata = mem_rdata;
        end else begin
          d_ready = 1'b1;
          d_rdata = req_byte ? lane_ext : mem_rdata;
        end
      end
      WRITE: begin
        mem_wdata = req_wdata;
        d_ready   = 1'b1;
      end
      RMW_WR: begin
        // mem_rdata still holds the word read during RMW_RD.
        mem_wdata = lane_merged;
        d_ready   = 1'b1;
      end
      ERR: begin
        d_ready      = 1'b1;
        d_misaligned = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a 64-word synchronous memory,
// a word-array reference model, directed steps and randomized transactions.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_load = 1'b0;
  logic        d_store = 1'b0;
  logic [2:0]  d_mode = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_misaligned;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int nerr = 0;
  int nchk = 0;

  logic [31:0] mem [0:63];
  logic [31:0] model_mem [0:63];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rdata     (if_rdata),
    .d_load       (d_load),
    .d_store      (d_store),
    .d_mode       (d_mode),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ready      (d_ready),
    .d_rdata      (d_rdata),
    .d_misaligned (d_misaligned),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  // Synchronous single-port memory: read data appears the cycle after the read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    nchk++;
    assert (obs === req)
    else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction, expectations derived from the model memory.
  task automatic run_txn(input string tag, input bit fetch, input bit ld, input bit st,
                         input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wd);
    bit          illegal;
    int          exp_lat, exp_nrd, exp_nwr;
    int unsigned k, widx;
    logic [31:0] w, b, exp_rdata, exp_wdata;
    int          lat, nrd, nwr, rd_cyc, wr_cyc, nspur;
    logic [29:0] raddr, waddr;
    logic [31:0] wdata_seen, rdata_seen;
    logic        mis_seen, busy_seen;

    widx = (addr % 256) / 4;
    k    = addr % 4;
    w    = model_mem[widx];
    b    = (w >> (8 * k)) & 32'hFF;
    illegal = !fetch && ((ld && st) || (mode != 3'd1 && mode != 3'd2) ||
                         (mode == 3'd2 && k != 0));
    exp_rdata = '0;
    exp_wdata = '0;
    if (illegal) begin
      exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
    end else if (fetch || ld) begin
      exp_lat = 2; exp_nrd = 1; exp_nwr = 0;
      exp_rdata = (fetch || mode == 3'd2) ? w : ((b >= 128) ? b + 32'hFFFFFF00 : b);
    end else if (mode == 3'd2) begin
      exp_lat = 1; exp_nrd = 0; exp_nwr = 1;
      exp_wdata = wd;
    end else begin
      exp_lat = 2; exp_nrd = 1; exp_nwr = 1;
      exp_wdata = (w & ~(32'hFF << (8 * k))) | ((wd & 32'hFF) << (8 * k));
    end

    @(negedge clk);
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_load = ld; d_store = st; d_mode = mode; d_addr = addr; d_wdata = wd;
    end
    lat = 0; nrd = 0; nwr = 0; rd_cyc = 0; wr_cyc = 0; nspur = 0;
    raddr = '0; waddr = '0; wdata_seen = '0; rdata_seen = '0; mis_seen = 1'b0; busy_seen = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      if (c == 1) begin
        // The request is latched; withdraw and scramble it.
        #1;
        if_req = 1'b0; d_load = 1'b0; d_store = 1'b0;
        if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_mode = 3'($urandom);
      end
      @(negedge clk);
      if (mem_en) begin
        if (mem_we) begin nwr++; wr_cyc = c; waddr = mem_addr; wdata_seen = mem_wdata; end
        else begin nrd++; rd_cyc = c; raddr = mem_addr; end
      end
      if (fetch ? d_ready : if_ready) nspur++;
      if (fetch ? if_ready : d_ready) begin
        lat = c;
        rdata_seen = fetch ? if_rdata : d_rdata;
        mis_seen = fetch ? 1'b0 : d_misaligned;
        busy_seen = busy;
        break;
      end
    end

    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/reads"}, 64'(nrd), 64'(exp_nrd));
    check({tag, "/writes"}, 64'(nwr), 64'(exp_nwr));
    check({tag, "/spurious_ready"}, 64'(nspur), 64'd0);
    check({tag, "/misaligned"}, 64'(mis_seen), 64'(illegal));
    check({tag, "/busy"}, 64'(busy_seen), 64'd1);
    if (exp_nrd == 1) begin
      check({tag, "/read_cycle"}, 64'(rd_cyc), 64'd1);
      check({tag, "/read_addr"}, 64'(raddr), 64'(widx));
    end
    if (exp_nwr == 1) begin
      check({tag, "/write_cycle"}, 64'(wr_cyc), 64'(exp_lat));
      check({tag, "/write_addr"}, 64'(waddr), 64'(widx));
      check({tag, "/write_data"}, 64'(wdata_seen), 64'(exp_wdata));
      model_mem[widx] = exp_wdata;
    end else begin
      check({tag, "/rdata"}, 64'(rdata_seen), 64'(exp_rdata));
    end
    @(posedge clk);
    #1;
    check({tag, "/mem_word"}, 64'(mem[widx]), 64'(model_mem[widx]));
  endtask

  logic        ord  [0:3];
  logic [31:0] ordd [0:3];
  int          n;
  logic [31:0] v;

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset/ctl", {58'd0, busy, mem_en, mem_we, if_ready, d_ready, d_misaligned}, 64'd0);
    check("reset/mem_addr", 64'(mem_addr), 64'd0);
    check("reset/mem_wdata", 64'(mem_wdata), 64'd0);
    check("reset/rdata", {if_rdata, d_rdata}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole memory through word stores.
    for (int i = 0; i < 64; i++) begin
      v = (i == 4) ? 32'hDEADBEEF : $urandom;
      run_txn("fill_sw", 1'b0, 1'b0, 1'b1, 3'd2, 32'(i * 4), v);
    end

    // Both requesters held: data first after reset, then alternate.
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h43;
    d_load = 1'b1; d_store = 1'b0; d_mode = 3'd2; d_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin ord[i] = 1'bx; ordd[i] = 'x; end
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (d_ready) begin ord[n] = 1'b1; ordd[n] = d_rdata; n++; end
      else if (if_ready) begin ord[n] = 1'b0; ordd[n] = if_rdata; n++; end
    end
    if_req = 1'b0; d_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("arb/order", 64'(ord[i]), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("arb/rdata", 64'(ordd[i]), (i % 2 == 0) ? 64'(model_mem[8]) : 64'(model_mem[16]));
    end
    @(negedge clk);

    run_txn("lw_0x10", 1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    run_txn("sw_0x10", 1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h80112233);
    run_txn("lb_0x13", 1'b0, 1'b1, 1'b0, 3'd1, 32'h13, 32'h0);
    check("lb_0x13/model", 64'(((model_mem[4] >> 24) & 32'hFF) + 32'hFFFFFF00), 64'hFFFFFF80);
    run_txn("lb_0x12", 1'b0, 1'b1, 1'b0, 3'd1, 32'h12, 32'h0);
    run_txn("sw_0x10b", 1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h11223344);
    run_txn("sb_0x11", 1'b0, 1'b0, 1'b1, 3'd1, 32'h11, 32'h000000AB);
    check("sb_0x11/word", 64'(mem[4]), 64'h1122AB44);
    run_txn("sw_0x06", 1'b0, 1'b0, 1'b1, 3'd2, 32'h06, 32'h12345678);
    run_txn("ld_and_st", 1'b0, 1'b1, 1'b1, 3'd2, 32'h08, 32'h0);
    run_txn("mode3", 1'b0, 1'b1, 1'b0, 3'd3, 32'h08, 32'h0);
    run_txn("fetch_0x2f", 1'b1, 1'b0, 1'b0, 3'd0, 32'h2F, 32'h0);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      int unsigned r, a, sub;
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 255);
      case (r)
        0, 1: run_txn("rnd_fetch", 1'b1, 1'b0, 1'b0, 3'd0, 32'(a), 32'h0);
        2, 3: run_txn("rnd_lw", 1'b0, 1'b1, 1'b0, 3'd2, 32'(a & 32'hFC), 32'h0);
        4, 5: run_txn("rnd_lb", 1'b0, 1'b1, 1'b0, 3'd1, 32'(a), 32'h0);
        6:    run_txn("rnd_sw", 1'b0, 1'b0, 1'b1, 3'd2, 32'(a & 32'hFC), $urandom);
        7, 8: run_txn("rnd_sb", 1'b0, 1'b0, 1'b1, 3'd1, 32'(a), $urandom);
        default: begin
          sub = $urandom_range(0, 2);
          if (sub == 0)      run_txn("rnd_ldst", 1'b0, 1'b1, 1'b1, 3'd2, 32'(a & 32'hFC), $urandom);
          else if (sub == 1) run_txn("rnd_badmode", 1'b0, 1'b0, 1'b1,
                                     (a % 2 == 0) ? 3'd0 : 3'($urandom_range(3, 7)), 32'(a), $urandom);
          else               run_txn("rnd_misal", 1'b0, 1'b1, 1'b0, 3'd2,
                                     32'((a & 32'hFC) | $urandom_range(1, 3)), 32'h0);
        end
      endcase
    end

    // Reset during RMW_RD of a byte store.
    @(negedge clk);
    d_store = 1'b1; d_mode = 3'd1; d_addr = 32'h31; d_wdata = 32'h000000CD;
    @(posedge clk);
    #1;
    d_store = 1'b0;
    @(negedge clk);
    check("rmw_abort/in_read", {62'd0, mem_en, mem_we}, 64'd2);
    rst_n = 1'b0;
    #1;
    check("rmw_abort/ctl", {58'd0, busy, mem_en, mem_we, if_ready, d_ready, d_misaligned}, 64'd0);
    check("rmw_abort/mem_addr", 64'(mem_addr), 64'd0);
    check("rmw_abort/mem_wdata", 64'(mem_wdata), 64'd0);
    check("rmw_abort/rdata", {if_rdata, d_rdata}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rmw_abort/word", 64'(mem[12]), 64'(model_mem[12]));
    run_txn("rmw_abort/lw", 1'b0, 1'b1, 1'b0, 3'd2, 32'h30, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
